// File: rtl/down_timer_counter_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared types and constants for the down timer/counter block.
//   state_t        : controller states (IDLE after reset, RUN while counting,
//                    DONE once a one-shot count has expired or 0 was loaded)
//   DEFAULT_WIDTH  : default counter / load-value width in bits
// -----------------------------------------------------------------------------
package timer_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/down_timer_counter_if.sv
// -----------------------------------------------------------------------------
// down_timer_counter_if
// Control/status bundle between a controller and the down timer.
//   load        : load strobe, samples load_val on the clock edge
//   load_val    : start / reload value
//   en          : count enable
//   auto_reload : 1 = periodic, 0 = one-shot
//   q           : current count
//   zero        : q == 0 (combinational)
//   tc_pulse    : registered one-cycle terminal-count pulse
//   busy        : timer is counting
// master modport is the controller side, slave modport is the timer side.
// -----------------------------------------------------------------------------
interface down_timer_counter_if
    import timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] q;
    logic             zero;
    logic             tc_pulse;
    logic             busy;

    modport master (
        output load, load_val, en, auto_reload,
        input  q, zero, tc_pulse, busy
    );

    modport slave (
        input  load, load_val, en, auto_reload,
        output q, zero, tc_pulse, busy
    );

endinterface

// File: rtl/down_timer_counter_core.sv
// -----------------------------------------------------------------------------
// down_count_core
// WIDTH-bit count register with synchronous load and decrement and an
// asynchronous clear.
//   clk      : clock, posedge
//   rst      : asynchronous active-high clear (q -> 0)
//   load     : load load_val this edge (has priority over dec)
//   load_val : value to load
//   dec      : decrement this edge
//   q        : current count
//   is_one   : q == 1
//   is_zero  : q == 0
// -----------------------------------------------------------------------------
module down_count_core
    import timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] q,
    output logic             is_one,
    output logic             is_zero
);

    // A decrement request at 0 is dropped so the count can never wrap to
    // all-ones, whatever the controller asks for.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (dec && !is_zero) begin
            q <= q - WIDTH'(1);
        end
    end

    assign is_one  = (q == WIDTH'(1));
    assign is_zero = (q == '0);

endmodule

// File: rtl/down_timer_counter.sv
// -----------------------------------------------------------------------------
// down_timer_counter
// Loadable down counter / interval timer with one-shot and periodic
// auto-reload modes. Used as a delay/timeout source by control FSMs.
//   clk : clock, all state updates on posedge
//   rst : asynchronous active-high reset
//   bus : slave side of down_timer_counter_if
//         (load, load_val, en, auto_reload in; q, zero, tc_pulse, busy out)
// Per-edge priority: rst > load > count > hold.
// -----------------------------------------------------------------------------
module down_timer_counter
    import timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    down_timer_counter_if.slave bus
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] reload_reg;
    logic             tc_q;
    logic             tc_next;

    logic             terminal;
    logic             core_load;
    logic [WIDTH-1:0] core_val;
    logic             core_dec;
    logic [WIDTH-1:0] count;
    logic             is_one;
    logic             is_zero;

    // Terminal cycle: counting from 1 while running and not being reloaded
    // by software in the same edge.
    assign terminal = (state == RUN) && bus.en && is_one && !bus.load;

    // In periodic mode the terminal cycle reloads the core from reload_reg
    // instead of letting it reach 0, so q never shows 0 while periodic.
    assign core_load = bus.load || (terminal && bus.auto_reload);
    assign core_val  = bus.load ? bus.load_val : reload_reg;
    assign core_dec  = (state == RUN) && bus.en && !bus.load;

    down_count_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (core_load),
        .load_val (core_val),
        .dec      (core_dec),
        .q        (count),
        .is_one   (is_one),
        .is_zero  (is_zero)
    );

    // Next-state and terminal-pulse logic. A load of 0 goes straight to DONE
    // since there is nothing to count.
    always_comb begin
        state_next = state;
        tc_next    = 1'b0;
        if (bus.load) begin
            state_next = (bus.load_val != '0) ? RUN : DONE;
        end else if (terminal) begin
            tc_next = 1'b1;
            if (!bus.auto_reload) begin
                state_next = DONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tc_q       <= 1'b0;
            reload_reg <= '0;
        end else begin
            state <= state_next;
            tc_q  <= tc_next;
            if (bus.load) begin
                reload_reg <= bus.load_val;
            end
        end
    end

    assign bus.q        = count;
    assign bus.zero     = is_zero;
    assign bus.tc_pulse = tc_q;
    assign bus.busy     = (state == RUN);

endmodule

// File: doc/down_timer_counter.md
Name: down_timer_counter

Overview:
- Synchronous, loadable down counter / interval timer. It is the counting-down counterpart to the team's ripple up-counter.
- Software or a controller loads a start value. The block decrements on enabled clocks and flags terminal count.
- Two modes: one-shot, which stops at 0, and periodic auto-reload.
- Used as a delay/timeout source by control FSMs in the same design.

Parameters:
- WIDTH, 4, counter and load-value width in bits (min 2).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- load  input  1  load strobe; samples load_val this edge.
- load_val  input  WIDTH  start/reload value.
- en  input  1  count enable; decrement only when high.
- auto_reload  input  1  1 = periodic mode, 0 = one-shot; sampled at terminal cycle.
- q  output  WIDTH  current count.
- zero  output  1  combinational, q == 0.
- tc_pulse  output  1  registered one-cycle terminal-count pulse.
- busy  output  1  high while state == RUN.

Behaviour:
- Reset (async, any time incl. mid-count):
  - q=0, reload_reg=0, state=IDLE, tc_pulse=0, busy=0, zero=1.
  - Takes effect immediately, not at the next edge.
- States: IDLE (post-reset), RUN, DONE (one-shot expired). busy = (state==RUN).
- Priority per edge: rst > load > count > hold.
- load=1, any state:
  - q<=load_val, reload_reg<=load_val, tc_pulse<=0.
  - Next state = RUN if load_val!=0, else DONE.
  - en is ignored that cycle.
- RUN, en=1, q>1: q<=q-1, tc_pulse<=0.
- RUN, en=1, q==1 (terminal cycle): tc_pulse<=1.
  - auto_reload=1: q<=reload_reg, stay RUN. q never shows 0 in periodic mode; period = reload_reg enabled cycles.
  - auto_reload=0: q<=0, state<=DONE. busy falls on the same edge that q reaches 0.
- RUN, en=0: q and state hold, tc_pulse<=0.
- IDLE/DONE: q holds, en ignored, tc_pulse<=0.
- No wrap-around: q never decrements below 0; the 0 -> all-ones transition never occurs.
- reload_reg==1 with auto_reload: tc_pulse high every enabled cycle, q stays 1.
- tc_pulse is never high two cycles in a row unless en is held high with reload_reg==1.
- Latency:
  - Load to q visible: 1 edge.
  - Load of N (N>=1) to tc_pulse: N enabled edges after the load edge.
- auto_reload change mid-run affects only the next terminal cycle.

Decomposition:
- Shared package (timer_pkg):
  - State enum {IDLE, RUN, DONE}.
  - Default WIDTH constant.
- One natural sub-module, down_count_core:
  - WIDTH-bit register with sync load, decrement, async clear.
  - Outputs the is_one/is_zero detect.
  - The FSM and tc_pulse register stay in the top module.

Test Plan:
- Reset mid-run: load 9, en=1, assert rst between edges after 3 counts -> q=0, busy=0, zero=1, tc_pulse=0 immediately without a clock edge; after release, en alone does not change q.
- One-shot: load 5, auto_reload=0, en=1 -> q 5,4,3,2,1,0 on successive edges; tc_pulse high exactly the cycle q==0; busy drops the same edge; q stays 0 for 10 further cycles with no tc_pulse.
- Periodic: load 3, auto_reload=1, en=1 -> q 3,2,1,3,2,1,3; tc_pulse high each time q returns to 3 (every 3rd cycle); busy stays 1.
- Enable gating: load 4, en pattern 1,0,1,0,... -> q decrements only on en=1 edges; reaches 0 after 8 edges; tc_pulse once.
- Load priority / boundary: at q==1 with en=1, assert load=9 -> q=9 next cycle, no tc_pulse. Load 0 -> q=0, busy=0, state DONE, no tc_pulse. WIDTH=4, load 15 -> 15 enabled edges to 0, no wrap to 15.
